// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data memory that answers a single core
// memory-stage request per transaction with a fixed, parameterised latency.
//
// Ports
//   clk, rst              : clock; synchronous active-high reset
//   req_valid / req_ready : request handshake (ready only while idle)
//   req_we                : 1 = store, 0 = load
//   req_addr              : byte address (word index = addr[31:2])
//   req_wdata, req_be     : store data and per-byte enables
//   resp_valid/resp_ready : response handshake
//   resp_rdata            : load data, 0 for stores and errors
//   resp_err              : misaligned or out-of-range request
//
// The storage itself is never reset.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic          addr_err;
    logic [AW-1:0] idx;
    logic [31:0]   mem_rd;
    logic          mem_wr;

    assign idx      = addr_q[AW+1:2];
    assign addr_err = (addr_q[1:0] != 2'b00) ||
                      ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS));
    assign mem_rd   = mem[idx];

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        mem_wr     = 1'b0;
        req_ready  = (state_q == IDLE);
        resp_valid = (state_q == RESP);

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    // Array access happens on the edge that enters RESP, so a
                    // reset landing on that edge still suppresses the store.
                    state_d = RESP;
                    if (addr_err) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end else if (we_q) begin
                        mem_wr  = 1'b1;
                        rdata_d = '0;
                        err_d   = 1'b0;
                    end else begin
                        rdata_d = mem_rd;
                        err_d   = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Byte-enabled write; reset blocks the commit but never clears contents.
    always_ff @(posedge clk) begin
        if (mem_wr && !rst) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a scoreboard of expected responses
// is filled as requests are accepted and drained as responses handshake.
// A second instance with zero wait states checks the minimum-latency timing.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned W     = 2;

    logic        clk;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;

    logic        z_req_valid, z_req_ready, z_req_we;
    logic [31:0] z_req_addr, z_req_wdata;
    logic [3:0]  z_req_be;
    logic        z_resp_valid, z_resp_ready, z_resp_err;
    logic [31:0] z_resp_rdata;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
        .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
        .resp_rdata(z_resp_rdata), .resp_err(z_resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned acc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [DEPTH];
    int unsigned hs_edge  = 0;
    int unsigned acc_edge = 0;

    // Response monitor: latency at first resp_valid, data at handshake.
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (resp_valid && !prev_valid) begin
                if (sb.size() == 0) check("resp_unexpected", 32'd1, 32'd0);
                else check("resp_latency", cyc - sb[0].acc, W + 1);
            end
            if (resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    check("hs_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("rdata", resp_rdata, e.rdata);
                    check("err", {31'b0, resp_err}, {31'b0, e.err});
                    hs_edge = cyc + 1;
                end
            end
            prev_valid = resp_valid;
        end
    end

    task automatic send(input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
        exp_t        e;
        logic        err;
        logic [29:0] wi;
        bit          ok;
        ok = 1'b0;
        @(posedge clk); #1;
        req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        req_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            check("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        wi    = addr[31:2];
        err   = (addr[1:0] != 2'b00) || (wi >= 30'(DEPTH));
        e.err = err;
        e.rdata = '0;
        e.acc = cyc + 1;
        if (!err) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) model[wi[7:0]][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                e.rdata = model[wi[7:0]];
            end
        end
        sb.push_back(e);
        acc_edge = cyc + 1;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0) begin done = 1'b1; break; end
            @(negedge clk);
        end
        if (!done) begin
            check("drain_timeout", 32'd0, 32'd1);
            sb.delete();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout got=running exp=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        bit ok;
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        resp_ready = 1'b1;
        z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_req_be = '0;
        z_resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_req_ready",  {31'b0, req_ready},  32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_rdata",      resp_rdata,          32'd0);
        check("rst_err",        {31'b0, resp_err},   32'd0);
        check("rst_z_ready",    {31'b0, z_req_ready}, 32'd1);

        // Word store then load.
        send(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        send(1'b0, 32'h10, 32'h0, 4'h0);
        // Partial store.
        send(1'b1, 32'h20, 32'h11223344, 4'hF);
        send(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
        send(1'b0, 32'h20, 32'h0, 4'h0);
        drain();
        check("partial_model", model[8], 32'h11BB33DD);

        // Errors and range boundaries.
        send(1'b1, 32'h0, 32'hCAFEF00D, 4'hF);
        send(1'b0, 32'h13, 32'h0, 4'h0);
        send(1'b1, 32'(4 * DEPTH), 32'hFFFFFFFF, 4'hF);
        send(1'b0, 32'h0, 32'h0, 4'h0);
        send(1'b1, 32'(4 * (DEPTH - 1)), 32'h0BADCAFE, 4'hF);
        send(1'b0, 32'(4 * (DEPTH - 1)), 32'h0, 4'h0);
        send(1'b0, 32'(4 * DEPTH), 32'h0, 4'h0);
        // Empty byte-enable store is a silent no-op.
        send(1'b1, 32'h0, 32'h12345678, 4'h0);
        send(1'b0, 32'h0, 32'h0, 4'h0);
        drain();

        // Backpressure with a second request held pending.
        @(posedge clk); #1 resp_ready = 1'b0;
        send(1'b0, 32'h10, 32'h0, 4'h0);
        fork
            begin
                ok = 1'b0;
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (resp_valid) begin ok = 1'b1; break; end
                end
                if (!ok) check("bp_resp_timeout", 32'd0, 32'd1);
                for (int i = 0; i < 5; i++) begin
                    if (i > 0) @(negedge clk);
                    check("bp_valid", {31'b0, resp_valid}, 32'd1);
                    check("bp_rdata", resp_rdata, 32'hDEADBEEF);
                    check("bp_err",   {31'b0, resp_err}, 32'd0);
                    check("bp_ready", {31'b0, req_ready}, 32'd0);
                end
                @(posedge clk); #1 resp_ready = 1'b1;
            end
            begin
                send(1'b1, 32'h30, 32'h01020304, 4'hF);
            end
        join
        check("bp_accept_after_hs", acc_edge - hs_edge, 32'd1);
        send(1'b0, 32'h30, 32'h0, 4'h0);
        drain();

        // Reset early in WAIT aborts the store.
        send(1'b1, 32'h40, 32'h600DF00D, 4'hF);
        drain();
        @(posedge clk); #1;
        req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h55; req_be = 4'hF; req_valid = 1'b1;
        @(negedge clk);
        check("abort_accept", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1 req_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("abort_ready", {31'b0, req_ready}, 32'd1);
        check("abort_rdata", resp_rdata, 32'd0);
        check("abort_err",   {31'b0, resp_err}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            check("abort_no_resp", {31'b0, resp_valid}, 32'd0);
            @(negedge clk);
        end
        send(1'b0, 32'h40, 32'h0, 4'h0);
        drain();

        // Reset coinciding with the WAIT->RESP edge still blocks the write.
        @(posedge clk); #1;
        req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h77; req_be = 4'hF; req_valid = 1'b1;
        @(negedge clk);
        check("abort2_accept", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("abort2_no_resp", {31'b0, resp_valid}, 32'd0);
        send(1'b0, 32'h40, 32'h0, 4'h0);
        drain();

        // Randomised traffic over a small window of words.
        for (int i = 0; i < 16; i++) send(1'b1, 32'h80 + 32'(4 * i), $urandom, 4'hF);
        for (int i = 0; i < 32; i++)
            send(1'($urandom_range(0, 1)), 32'h80 + 32'(4 * $urandom_range(0, 15)),
                 $urandom, 4'($urandom_range(0, 15)));
        drain();

        // Zero wait states: store then load back-to-back.
        @(posedge clk); #1;
        z_req_we = 1'b1; z_req_addr = 32'h8; z_req_wdata = 32'hA5A5A5A5; z_req_be = 4'hF;
        z_req_valid = 1'b1;
        @(negedge clk);
        check("z_acc1_ready", {31'b0, z_req_ready}, 32'd1);
        @(posedge clk); #1;
        z_req_we = 1'b0; z_req_wdata = '0; z_req_be = '0;
        @(negedge clk);
        check("z_wait_valid", {31'b0, z_resp_valid}, 32'd0);
        check("z_wait_ready", {31'b0, z_req_ready},  32'd0);
        @(negedge clk);
        check("z_resp1_valid", {31'b0, z_resp_valid}, 32'd1);
        check("z_resp1_rdata", z_resp_rdata, 32'd0);
        check("z_resp1_err",   {31'b0, z_resp_err}, 32'd0);
        @(negedge clk);
        check("z_acc2_ready", {31'b0, z_req_ready}, 32'd1);
        @(posedge clk); #1 z_req_valid = 1'b0;
        @(negedge clk);
        check("z_wait2_valid", {31'b0, z_resp_valid}, 32'd0);
        @(negedge clk);
        check("z_resp2_valid", {31'b0, z_resp_valid}, 32'd1);
        check("z_resp2_rdata", z_resp_rdata, 32'hA5A5A5A5);
        @(negedge clk);
        check("z_idle_ready", {31'b0, z_req_ready},  32'd1);
        check("z_idle_valid", {31'b0, z_resp_valid}, 32'd0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
